// File: rtl/dma_pkg.sv
// Shared types and widths for the block-copy engine in front of DataMem.
package dma_pkg;

  localparam int unsigned DMA_AW  = 8;
  localparam int unsigned DMA_DW  = 8;
  localparam int unsigned DMA_LW  = 8;

  // IDLE: pass-through, RD: fetch source byte, WR: store it, FIN: done pulse
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/mem_copy_dma.sv
// Block-copy engine sitting directly in front of DataMem.
// Copies Len bytes from SrcAddr.. to DstAddr.. one byte per two cycles
// (RD then WR); when not copying, the core's address/write signals pass
// straight through to the memory.
//
// Ports
//   Clk, Reset             clock, synchronous active-high reset
//   Start, SrcAddr,
//   DstAddr, Len           copy request, captured only in IDLE
//   CpuAddr, CpuWrEn,
//   CpuDataIn              core data-side request (ignored while Busy)
//   MemDataOut             DataMem combinational read data at MemAddr
//   MemAddr, MemWrEn,
//   MemDataIn              DataMem address / write enable / write data
//   Busy                   engine owns the memory (RD or WR)
//   Done                   one-cycle completion pulse (FIN)
module mem_copy_dma
  import dma_pkg::*;
#(
  parameter int unsigned AW = DMA_AW,
  parameter int unsigned DW = DMA_DW
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [AW-1:0]       SrcAddr,
  input  logic [AW-1:0]       DstAddr,
  input  logic [DMA_LW-1:0]   Len,
  input  logic [AW-1:0]       CpuAddr,
  input  logic                CpuWrEn,
  input  logic [DW-1:0]       CpuDataIn,
  input  logic [DW-1:0]       MemDataOut,
  output logic [AW-1:0]       MemAddr,
  output logic                MemWrEn,
  output logic [DW-1:0]       MemDataIn,
  output logic                Busy,
  output logic                Done
);

  dma_state_t          state_q,     state_d;
  logic [AW-1:0]       src_ptr_q,   src_ptr_d;
  logic [AW-1:0]       dst_ptr_q,   dst_ptr_d;
  logic [DMA_LW-1:0]   remaining_q, remaining_d;
  logic [DW-1:0]       hold_q,      hold_d;

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
    end
  end

  // Next-state logic and memory-port mux
  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;
    MemAddr     = CpuAddr;
    MemWrEn     = CpuWrEn;
    MemDataIn   = CpuDataIn;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          if (Len != '0) begin
            src_ptr_d   = SrcAddr;
            dst_ptr_d   = DstAddr;
            remaining_d = Len;
            state_d     = RD;
          end else begin
            state_d = FIN;
          end
        end
      end
      RD: begin
        MemAddr   = src_ptr_q;
        MemWrEn   = 1'b0;
        hold_d    = MemDataOut;
        src_ptr_d = src_ptr_q + AW'(1);
        state_d   = WR;
      end
      WR: begin
        MemAddr     = dst_ptr_q;
        MemWrEn     = 1'b1;
        MemDataIn   = hold_q;
        dst_ptr_d   = dst_ptr_q + AW'(1);
        remaining_d = remaining_q - DMA_LW'(1);
        state_d     = (remaining_q == DMA_LW'(1)) ? FIN : RD;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // No write may reach memory while reset is held
    if (Reset) MemWrEn = 1'b0;
  end

  assign Busy = (state_q == RD) || (state_q == WR);
  assign Done = (state_q == FIN);

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma with a behavioural DataMem behind it.
module tb_mem_copy_dma;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [7:0] SrcAddr, DstAddr, Len;
  logic [7:0] CpuAddr, CpuDataIn;
  logic       CpuWrEn;
  logic [7:0] MemDataOut, MemAddr, MemDataIn;
  logic       MemWrEn, Busy, Done;

  logic [7:0] mem [256];

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  mem_copy_dma dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .SrcAddr    (SrcAddr),
    .DstAddr    (DstAddr),
    .Len        (Len),
    .CpuAddr    (CpuAddr),
    .CpuWrEn    (CpuWrEn),
    .CpuDataIn  (CpuDataIn),
    .MemDataOut (MemDataOut),
    .MemAddr    (MemAddr),
    .MemWrEn    (MemWrEn),
    .MemDataIn  (MemDataIn),
    .Busy       (Busy),
    .Done       (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // DataMem: combinational read, registered write, cleared by Reset
  assign MemDataOut = mem[MemAddr];
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (MemWrEn) begin
      mem[MemAddr] <= MemDataIn;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every memory write must match the next expected write
  always @(negedge Clk) begin
    if (!Reset && MemWrEn) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 MemAddr, MemDataIn);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (MemAddr !== e.addr || MemDataIn !== e.data) begin
          failures++;
          $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   MemAddr, MemDataIn, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    expect_wr(a, d);
    CpuAddr   = a;
    CpuDataIn = d;
    CpuWrEn   = 1'b1;
    tick();
    CpuWrEn   = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    CpuAddr = a;
    #1;
    check(name, 32'(MemDataOut), 32'(exp));
  endtask

  // Issue Start in cycle 0, then count Busy cycles and find the Done cycle
  task automatic run_copy(input string name, input logic [7:0] src, input logic [7:0] dst,
                          input logic [7:0] len, input int exp_busy, input int exp_done);
    int busy_cnt;
    int done_c;
    busy_cnt = 0;
    done_c   = -1;
    SrcAddr = src;
    DstAddr = dst;
    Len     = len;
    Start   = 1'b1;
    tick();
    Start   = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      if (Busy) busy_cnt++;
      if (Done) begin
        done_c = c;
        break;
      end
      tick();
    end
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({name, "_done_cycle"}, 32'(done_c), 32'(exp_done));
    tick();
  endtask

  initial begin
    int done_seen;
    int busy_cnt;
    Reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0;
    CpuAddr = 8'h05; CpuWrEn = 1'b1; CpuDataIn = 8'h99;
    tick();
    check("reset_memwren", 32'(MemWrEn), 32'd0);
    check("reset_busy",    32'(Busy),    32'd0);
    check("reset_done",    32'(Done),    32'd0);
    tick();
    CpuWrEn = 1'b0;
    Reset   = 1'b0;
    tick();

    // 1: basic copy
    cpu_write(8'h10, 8'hA1);
    cpu_write(8'h11, 8'hB2);
    cpu_write(8'h12, 8'hC3);
    cpu_write(8'h13, 8'hD4);
    expect_wr(8'h80, 8'hA1);
    expect_wr(8'h81, 8'hB2);
    expect_wr(8'h82, 8'hC3);
    expect_wr(8'h83, 8'hD4);
    run_copy("t1", 8'h10, 8'h80, 8'd4, 8, 9);
    read_check("t1_m80", 8'h80, 8'hA1);
    read_check("t1_m81", 8'h81, 8'hB2);
    read_check("t1_m82", 8'h82, 8'hC3);
    read_check("t1_m83", 8'h83, 8'hD4);

    // 2: zero length is a no-op apart from Done
    run_copy("t2", 8'h10, 8'h80, 8'd0, 0, 1);
    read_check("t2_m80", 8'h80, 8'hA1);

    // 3: source wraps 0xFF -> 0x00
    cpu_write(8'hFE, 8'h11);
    cpu_write(8'hFF, 8'h22);
    cpu_write(8'h00, 8'h33);
    cpu_write(8'h01, 8'h44);
    expect_wr(8'h40, 8'h11);
    expect_wr(8'h41, 8'h22);
    expect_wr(8'h42, 8'h33);
    expect_wr(8'h43, 8'h44);
    run_copy("t3", 8'hFE, 8'h40, 8'd4, 8, 9);
    read_check("t3_m40", 8'h40, 8'h11);
    read_check("t3_m43", 8'h43, 8'h44);

    // 4: overlapping ascending copy replicates the first byte
    cpu_write(8'h20, 8'h5A);
    expect_wr(8'h21, 8'h5A);
    expect_wr(8'h22, 8'h5A);
    expect_wr(8'h23, 8'h5A);
    run_copy("t4", 8'h20, 8'h21, 8'd3, 6, 7);
    read_check("t4_m21", 8'h21, 8'h5A);
    read_check("t4_m23", 8'h23, 8'h5A);

    // 6: core writes and Start pulses while Busy are ignored
    expect_wr(8'h84, 8'hA1);
    expect_wr(8'h85, 8'hB2);
    SrcAddr = 8'h10; DstAddr = 8'h84; Len = 8'd2; Start = 1'b1;
    tick();
    done_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c <= 3) begin
        CpuAddr = 8'h80; CpuDataIn = 8'hEE; CpuWrEn = 1'b1;
        SrcAddr = 8'h20; DstAddr = 8'h60; Len = 8'd5; Start = 1'b1;
      end else begin
        CpuWrEn = 1'b0; Start = 1'b0;
      end
      #1;
      if (Done) begin
        done_seen = c;
        break;
      end
      tick();
    end
    check("t6_done_cycle", 32'(done_seen), 32'd5);
    // Start presented during FIN must not launch a copy
    SrcAddr = 8'h10; DstAddr = 8'h70; Len = 8'd1; Start = 1'b1;
    tick();
    Start = 1'b0;
    check("t6_fin_start_idle", 32'(Busy), 32'd0);
    tick();
    check("t6_fin_start_nobusy", 32'(Busy), 32'd0);
    read_check("t6_m80", 8'h80, 8'hA1);
    read_check("t6_m84", 8'h84, 8'hA1);
    read_check("t6_m85", 8'h85, 8'hB2);
    read_check("t6_m70", 8'h70, 8'h00);
    tick();
    cpu_write(8'h05, 8'h77);
    read_check("t6_m05", 8'h05, 8'h77);
    tick();

    // 5: reset during the WR of byte 1 aborts the copy
    expect_wr(8'hA0, 8'hA1);
    SrcAddr = 8'h10; DstAddr = 8'hA0; Len = 8'd4; Start = 1'b1;
    tick();                     // cycle 1 RD
    Start = 1'b0;
    tick();                     // cycle 2 WR byte 0
    tick();                     // cycle 3 RD
    tick();                     // cycle 4 WR byte 1
    check("t5_busy_in_wr", 32'(Busy), 32'd1);
    Reset = 1'b1;
    tick();                     // cycle 5
    Reset = 1'b0;
    check("t5_busy_after_reset", 32'(Busy), 32'd0);
    done_seen = 0;
    busy_cnt  = 0;
    for (int c = 0; c < 10; c++) begin
      if (Done) done_seen++;
      if (Busy) busy_cnt++;
      tick();
    end
    check("t5_no_done", 32'(done_seen), 32'd0);
    check("t5_stays_idle", 32'(busy_cnt), 32'd0);
    read_check("t5_cleared_a0", 8'hA0, 8'h00);
    cpu_write(8'h30, 8'hE1);
    cpu_write(8'h31, 8'hE2);
    expect_wr(8'h90, 8'hE1);
    expect_wr(8'h91, 8'hE2);
    run_copy("t5_restart", 8'h30, 8'h90, 8'd2, 4, 5);
    read_check("t5_m90", 8'h90, 8'hE1);
    read_check("t5_m91", 8'h91, 8'hE2);

    tick();
    tick();
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
